// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the CPU memory stage
// (master) and the data-memory responder (slave).
//   req_valid/req_ready : request handshake, carries req_we/req_addr/req_wdata
//   rsp_valid/rsp_ready : response handshake, carries rsp_rdata/rsp_err
//   inj_par_err         : parity-error injection on stores (only when
//                         DMEM_PARITY_EN is defined)
interface dmem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
`ifdef DMEM_PARITY_EN
    logic              inj_par_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, inj_par_err,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, inj_par_err,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory target for the CPU memory
// stage. Accepts a load/store, waits WAIT_CYCLES, performs the access on
// internal word storage and holds the response until it is taken.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : dmem_responder_if.slave (request and response handshakes)
// Optional: define DMEM_PARITY_EN to store an even-parity bit per word,
// add inj_par_err to the bus, and flag parity mismatches on loads.
// Latency: with WAIT_CYCLES=0 the response is valid right after the accept
// edge; otherwise it becomes valid after accept edge + 1 + WAIT_CYCLES.
module dmem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int                CNT_W     = 4;
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(WAIT_CYCLES);
    // One extra bit so DEPTH = 2**ADDR_W is representable and the range
    // compare never degenerates into a constant.
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                accept;
    logic                rsp_hs;
    logic                acc_fire;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_in_range;
    logic [DATA_W-1:0]   rd_word;
    logic                par_bad;

`ifdef DMEM_PARITY_EN
    logic                inj_q, inj_d;
    logic                acc_inj;
    logic                par_q [DEPTH];
    logic                rd_par;
`endif

    assign accept = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
    assign rsp_hs = rsp_valid_q && bus.rsp_ready;

    // The access uses the live request when it happens on the accept edge
    // (zero wait states), otherwise the captured request.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

`ifdef DMEM_PARITY_EN
    assign acc_inj = (state_q == S_IDLE) ? bus.inj_par_err : inj_q;
`endif

    assign acc_in_range = ({1'b0, acc_addr} < DEPTH_L);
    assign rd_word      = acc_in_range ? mem_q[acc_addr] : '0;

`ifdef DMEM_PARITY_EN
    assign rd_par  = acc_in_range ? par_q[acc_addr] : 1'b0;
    assign par_bad = acc_in_range && !acc_we && (rd_par != ^rd_word);
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef DMEM_PARITY_EN
        inj_d       = inj_q;
`endif
        acc_fire    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // req_ready comes up one edge after reset release.
                req_ready_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
`ifdef DMEM_PARITY_EN
                    inj_d       = bus.inj_par_err;
`endif
                    cnt_d       = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        acc_fire = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    acc_fire = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                // Return to IDLE with req_ready set; the accept can only
                // happen on the following edge, giving one bubble cycle.
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        if (acc_fire) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (!acc_we && acc_in_range) ? rd_word : '0;
            rsp_err_d   = !acc_in_range || par_bad;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
`ifdef DMEM_PARITY_EN
            inj_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef DMEM_PARITY_EN
            inj_q       <= inj_d;
`endif
        end
    end

    // Storage is not reset. Writes are gated by acc_fire, which depends on
    // reset-cleared state, so a store dropped by reset never commits.
    always_ff @(posedge clk) begin
        if (acc_fire && acc_we && acc_in_range) begin
            mem_q[acc_addr] <= acc_wdata;
`ifdef DMEM_PARITY_EN
            par_q[acc_addr] <= (^acc_wdata) ^ acc_inj;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0: DEPTH=256, zero wait states;
// 1: DEPTH=200, two wait states) driven with random loads/stores and
// checked against an array-based memory model.
module tb_dmem_responder;
    localparam int DW = 16;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          rsp_ready [2];
    logic          inj       [2];

    logic          req_ready_o [2];
    logic          rsp_valid_o [2];
    logic [DW-1:0] rsp_rdata_o [2];
    logic          rsp_err_o   [2];

    dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.req_valid = req_valid[0];
    assign bus0.req_we    = req_we[0];
    assign bus0.req_addr  = req_addr[0];
    assign bus0.req_wdata = req_wdata[0];
    assign bus0.rsp_ready = rsp_ready[0];
    assign bus1.req_valid = req_valid[1];
    assign bus1.req_we    = req_we[1];
    assign bus1.req_addr  = req_addr[1];
    assign bus1.req_wdata = req_wdata[1];
    assign bus1.rsp_ready = rsp_ready[1];
`ifdef DMEM_PARITY_EN
    assign bus0.inj_par_err = inj[0];
    assign bus1.inj_par_err = inj[1];
`endif
    assign req_ready_o[0] = bus0.req_ready;
    assign rsp_valid_o[0] = bus0.rsp_valid;
    assign rsp_rdata_o[0] = bus0.rsp_rdata;
    assign rsp_err_o[0]   = bus0.rsp_err;
    assign req_ready_o[1] = bus1.req_ready;
    assign rsp_valid_o[1] = bus1.rsp_valid;
    assign rsp_rdata_o[1] = bus1.rsp_rdata;
    assign rsp_err_o[1]   = bus1.rsp_err;

    dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .WAIT_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Reference model: depth, response latency (negedges after accept edge
    // until rsp_valid is seen) and word/parity contents per instance.
    int            dep     [2] = '{256, 200};
    int            lat     [2] = '{0, 3};
    logic [DW-1:0] mdl     [2][256];
    bit            pbad    [2][256];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One full transaction on instance d, starting and ending at a negedge
    // with the DUT idle. The response is held off for 'hold' cycles.
    task automatic txn(input int d, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input bit inj_e, input int hold);
        int n;
        int k;
        bit exp_err;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] rd0;
        logic err0;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        inj[d]       = inj_e;
        n = 0;
        while (!req_ready_o[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o[d]) begin
            chk("accept_timeout", 0, 1);
            req_valid[d] = 1'b0;
            return;
        end
        // model at the accept edge
        exp_err = (int'(addr) >= dep[d]);
        exp_rd  = '0;
        if (!exp_err) begin
            if (we) begin
                mdl[d][addr]  = wdata;
                pbad[d][addr] = inj_e;
            end else begin
                exp_rd  = mdl[d][addr];
                exp_err = pbad[d][addr];
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        inj[d]       = 1'b0;
        k = 0;
        while (!rsp_valid_o[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("lat%0d", d), k, lat[d]);
        chk($sformatf("rdata%0d@%0h", d, addr), 32'(rsp_rdata_o[d]), 32'(exp_rd));
        chk($sformatf("err%0d@%0h", d, addr), 32'(rsp_err_o[d]), 32'(exp_err));
        chk("rdy_low_in_resp", 32'(req_ready_o[d]), 0);
        rd0  = rsp_rdata_o[d];
        err0 = rsp_err_o[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid_o[d]), 1);
            chk("hold_rdata", 32'(rsp_rdata_o[d]), 32'(rd0));
            chk("hold_err", 32'(rsp_err_o[d]), 32'(err0));
            chk("hold_rdy", 32'(req_ready_o[d]), 0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("post_valid", 32'(rsp_valid_o[d]), 0);
        chk("post_rdata", 32'(rsp_rdata_o[d]), 0);
        chk("post_err", 32'(rsp_err_o[d]), 0);
        chk("post_rdy", 32'(req_ready_o[d]), 1);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'hC8;
        if (r == 1) return AW'($urandom_range(199, 255));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        logic [AW-1:0] ba [9];
        logic [DW-1:0] old03;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; rsp_ready[d] = 1'b0; inj[d] = 1'b0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdy", 32'(req_ready_o[d]), 0);
            chk("rst_valid", 32'(rsp_valid_o[d]), 0);
            chk("rst_rdata", 32'(rsp_rdata_o[d]), 0);
            chk("rst_err", 32'(rsp_err_o[d]), 0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst0", 32'(req_ready_o[0]), 1);
        chk("rdy_after_rst1", 32'(req_ready_o[1]), 1);

        // preload every address the random traffic may load
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 32; a++) txn(d, 1'b1, AW'(a), DW'($urandom), 1'b0, 0);
            for (int a = 199; a < 256; a++) txn(d, 1'b1, AW'(a), DW'($urandom), 1'b0, 0);
        end

        // directed store/load with two wait states
        txn(1, 1'b1, 8'h05, 16'hBEEF, 1'b0, 0);
        txn(1, 1'b0, 8'h05, 16'h0000, 1'b0, 0);

        // random traffic on both instances
        for (int i = 0; i < 60; i++) begin
            txn(i % 2, 1'($urandom_range(0, 1)), pick_addr(), DW'($urandom), 1'b0,
                $urandom_range(0, 3));
        end

        // backpressure: response held for 10 cycles
        txn(1, 1'b0, 8'h10, 16'h0000, 1'b0, 10);

        // out-of-range boundary on the DEPTH=200 instance
        txn(1, 1'b1, 8'hC8, 16'h1234, 1'b0, 0);
        txn(1, 1'b0, 8'hC8, 16'h0000, 1'b0, 0);
        txn(1, 1'b0, 8'hC7, 16'h0000, 1'b0, 0);

        // back-to-back loads, zero wait states, rsp_ready tied high:
        // response / bubble alternate every cycle
        for (int j = 0; j < 9; j++) ba[j] = AW'($urandom_range(0, 31));
        rsp_ready[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = ba[0];
        req_valid[0] = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                chk("b2b_valid", 32'(rsp_valid_o[0]), 1);
                chk("b2b_rdata", 32'(rsp_rdata_o[0]), 32'(mdl[0][ba[(c-1)/2]]));
                chk("b2b_rdy", 32'(req_ready_o[0]), 0);
                req_addr[0] = ba[(c+1)/2];
            end else begin
                chk("b2b_bubble", 32'(rsp_valid_o[0]), 0);
                chk("b2b_rdy", 32'(req_ready_o[0]), 1);
                if (c == 16) begin
                    req_valid[0] = 1'b0;
                    rsp_ready[0] = 1'b0;
                end
            end
        end
        @(negedge clk);

        // reset while a store sits in WAIT: store must not commit
        old03 = mdl[1][3];
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 8'h03; req_wdata[1] = 16'hAAAA;
        chk("rst_mid_rdy", 32'(req_ready_o[1]), 1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid_o[1]), 0);
        chk("rst_mid_rdy_lo", 32'(req_ready_o[1]), 0);
        chk("rst_mid_rdata", 32'(rsp_rdata_o[1]), 0);
        chk("rst_mid_err", 32'(rsp_err_o[1]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        txn(1, 1'b0, 8'h03, 16'h0000, 1'b0, 0);
        chk("rst_old03", 32'(mdl[1][3]), 32'(old03 ^ 16'h0000));

`ifdef DMEM_PARITY_EN
        txn(1, 1'b1, 8'h07, 16'h00FF, 1'b1, 0);
        txn(1, 1'b0, 8'h07, 16'h0000, 1'b0, 0);
        txn(1, 1'b1, 8'h07, 16'h00FF, 1'b0, 0);
        txn(1, 1'b0, 8'h07, 16'h0000, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
